key_event_detect: RTL and testbench

- Multi-channel key front end for generations after the single-shot press debouncer.
- Each channel gets:
  - an independent 2-FF synchroniser, press debounce and release debounce;
  - a debounced level output;
  - one-cycle press, release, long-press and auto-repeat event pulses.
- Sits between board pushbuttons and the control/mode-select logic; shares no state between channels.

---
 rtl/key_event_detect.sv | 146 ++++++++++++++
 tb/tb_key_event_detect.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/key_event_detect.sv
// key_event_detect: multi-channel key synchroniser, debouncer and press/release/long/repeat event generator
module key_event_detect #(
  parameter int KEY_W  = 4,
  parameter int CNT_W  = 26,
  parameter int T_DEB  = 500_000,
  parameter int T_LONG = 25_000_000,
  parameter int T_RPT  = 5_000_000,
  parameter int RPT_EN = 1,
  parameter int ACT_LVL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key_in,
  output logic [KEY_W-1:0] key_state,
  output logic [KEY_W-1:0] key_press,
  output logic [KEY_W-1:0] key_release,
  output logic [KEY_W-1:0] key_long,
  output logic [KEY_W-1:0] key_rpt
);

  typedef enum logic [2:0] {IDLE, PDEB, HELD, LONG, RDEB} state_t;

  localparam logic [KEY_W-1:0] REL_LVL = (ACT_LVL != 0) ? '0 : '1;
  localparam logic [CNT_W-1:0] DEB_M   = CNT_W'(T_DEB - 1);
  localparam logic [CNT_W-1:0] LONG_M  = CNT_W'(T_LONG - 1);
  localparam logic [CNT_W-1:0] RPT_M   = CNT_W'(T_RPT - 1);

  logic [KEY_W-1:0] ff0, ff1, p;

  // Two-stage synchroniser; reset loads the released level so reset exit is silent
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff0 <= REL_LVL;
      ff1 <= REL_LVL;
    end else begin
      ff0 <= key_in;
      ff1 <= ff0;
    end
  end

  assign p = (ACT_LVL != 0) ? ff1 : ~ff1;

  for (genvar g = 0; g < KEY_W; g++) begin : g_ch
    state_t           st, st_n;
    logic [CNT_W-1:0] tmr, tmr_n;
    logic             lng, lng_n, lvl, lvl_n;
    logic             prs, prs_n, rel, rel_n, lp, lp_n, rp, rp_n;

    // Next-state, timer and event decode; every state change clears the timer
    always_comb begin
      st_n  = st;
      tmr_n = tmr + 1'b1;
      lng_n = lng;
      lvl_n = lvl;
      prs_n = 1'b0;
      rel_n = 1'b0;
      lp_n  = 1'b0;
      rp_n  = 1'b0;
      case (st)
        IDLE: begin
          tmr_n = '0;
          if (p[g]) st_n = PDEB;
        end
        PDEB: begin
          if (!p[g]) begin
            st_n  = IDLE;
            tmr_n = '0;
          end else if (tmr == DEB_M) begin
            st_n  = HELD;
            tmr_n = '0;
            prs_n = 1'b1;
            lvl_n = 1'b1;
          end
        end
        HELD: begin
          if (!p[g]) begin
            st_n  = RDEB;
            tmr_n = '0;
          end else if (tmr == LONG_M) begin
            st_n  = LONG;
            tmr_n = '0;
            lp_n  = 1'b1;
            lng_n = 1'b1;
          end
        end
        LONG: begin
          if (!p[g]) begin
            st_n  = RDEB;
            tmr_n = '0;
          end else if (RPT_EN == 0) begin
            tmr_n = '0;
          end else if (tmr == RPT_M) begin
            tmr_n = '0;
            rp_n  = 1'b1;
          end
        end
        RDEB: begin
          if (p[g]) begin
            st_n  = lng ? LONG : HELD;
            tmr_n = '0;
          end else if (tmr == DEB_M) begin
            st_n  = IDLE;
            tmr_n = '0;
            rel_n = 1'b1;
            lvl_n = 1'b0;
            lng_n = 1'b0;
          end
        end
        default: begin
          st_n  = IDLE;
          tmr_n = '0;
        end
      endcase
    end

    // Per-channel state, timer, long flag and registered event outputs
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st  <= IDLE;
        tmr <= '0;
        lng <= 1'b0;
        lvl <= 1'b0;
        prs <= 1'b0;
        rel <= 1'b0;
        lp  <= 1'b0;
        rp  <= 1'b0;
      end else begin
        st  <= st_n;
        tmr <= tmr_n;
        lng <= lng_n;
        lvl <= lvl_n;
        prs <= prs_n;
        rel <= rel_n;
        lp  <= lp_n;
        rp  <= rp_n;
      end
    end

    assign key_state[g]   = lvl;
    assign key_press[g]   = prs;
    assign key_release[g] = rel;
    assign key_long[g]    = lp;
    assign key_rpt[g]     = rp;
  end

endmodule

// File: tb/tb_key_event_detect.sv
// tb_key_event_detect: scoreboard bench for key_event_detect, active-high/repeat and active-low/no-repeat instances
module tb_key_event_detect;
  localparam int KW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [KW-1:0] key = '0;
  logic [KW-1:0] key_n;
  logic [KW-1:0] st_a, pr_a, rl_a, lg_a, rp_a;
  logic [KW-1:0] st_b, pr_b, rl_b, lg_b, rp_b;

  assign key_n = ~key;

  key_event_detect #(.KEY_W(KW), .CNT_W(8), .T_DEB(4), .T_LONG(10), .T_RPT(3), .RPT_EN(1), .ACT_LVL(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .key_in(key), .key_state(st_a), .key_press(pr_a),
    .key_release(rl_a), .key_long(lg_a), .key_rpt(rp_a));

  key_event_detect #(.KEY_W(KW), .CNT_W(8), .T_DEB(4), .T_LONG(10), .T_RPT(3), .RPT_EN(0), .ACT_LVL(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .key_in(key_n), .key_state(st_b), .key_press(pr_b),
    .key_release(rl_b), .key_long(lg_b), .key_rpt(rp_b));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int c; logic [15:0] ev;} exp_t;
  exp_t q[$];
  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, act, exp);
    end
  endtask

  // kind: 0 press, 1 release, 2 long, 3 rpt; events in the same cycle merge
  task automatic push(input int c, input int kind, input int ch);
    logic [15:0] m = 16'(1) << (kind * KW + ch);
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].c == c) begin
        q[i].ev |= m;
        return;
      end
      if (q[i].c > c) begin
        q.insert(i, '{c, m});
        return;
      end
    end
    q.push_back('{c, m});
  endtask

  // Key driven just after edge e, released just after edge E
  task automatic plan(input int ch, input int e, input int E, input bit rel);
    push(e + 7, 0, ch);
    if (e + 17 <= E + 2) push(e + 17, 2, ch);
    for (int t = e + 20; t <= E + 2; t += 3) push(t, 3, ch);
    if (rel) push(E + 7, 1, ch);
  endtask

  task automatic drv_at(input logic [KW-1:0] m, input bit v, input int E);
    while (cyc < E) begin
      @(posedge clk);
      #1;
    end
    key = v ? (key | m) : (key & ~m);
  endtask

  task automatic wait_to(input int c);
    @(negedge clk);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic chk_st(input string tag, input logic [KW-1:0] exp);
    chk({tag, "_a"}, 32'(st_a), 32'(exp));
    chk({tag, "_b"}, 32'(st_b), 32'(exp));
  endtask

  always @(negedge clk) begin
    logic [15:0] ex, ea, eb;
    if (rst_n) begin
      ex = '0;
      if (q.size() > 0 && q[0].c == cyc) begin
        ex = q[0].ev;
        void'(q.pop_front());
      end
      ea = {rp_a, lg_a, rl_a, pr_a};
      eb = {rp_b, lg_b, rl_b, pr_b};
      if (ea != 0 || ex != 0) chk("ev_a", 32'(ea), 32'(ex));
      if (eb != 0 || (ex & 16'h0fff) != 0) chk("ev_b", 32'(eb), 32'(ex & 16'h0fff));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e, g, r;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a", 32'({st_a, pr_a, rl_a, lg_a, rp_a}), 0);
    chk("rst_b", 32'({st_b, pr_b, rl_b, lg_b, rp_b}), 0);
    rst_n = 1'b1;
    // clean press, long hold with repeats, release
    e = cyc + 2;
    plan(0, e, e + 40, 1);
    drv_at(4'b0001, 1, e);
    wait_to(e + 6);
    chk_st("pre_press", 4'b0000);
    wait_to(e + 7);
    chk_st("press", 4'b0001);
    drv_at(4'b0001, 0, e + 40);
    wait_to(e + 46);
    chk_st("pre_rel", 4'b0001);
    wait_to(e + 47);
    chk_st("rel", 4'b0000);
    // bounce on channel 1
    e = cyc + 5;
    drv_at(4'b0010, 1, e);
    drv_at(4'b0010, 0, e + 3);
    drv_at(4'b0010, 1, e + 5);
    drv_at(4'b0010, 0, e + 8);
    wait_to(e + 16);
    chk_st("bounce", 4'b0000);
    // short release glitch during LONG
    e = cyc + 2;
    g = e + 22;
    plan(0, e, g, 0);
    for (int t = g + 8; t <= g + 22; t += 3) push(t, 3, 0);
    push(g + 27, 1, 0);
    drv_at(4'b0001, 1, e);
    drv_at(4'b0001, 0, g);
    drv_at(4'b0001, 1, g + 2);
    wait_to(g + 6);
    chk_st("glitch", 4'b0001);
    drv_at(4'b0001, 0, g + 20);
    wait_to(g + 28);
    chk_st("glitch_rel", 4'b0000);
    // simultaneous press on 0 and 3, early release of 3
    e = cyc + 2;
    plan(0, e, e + 30, 1);
    plan(3, e, e + 12, 1);
    drv_at(4'b1001, 1, e);
    wait_to(e + 7);
    chk_st("dual", 4'b1001);
    drv_at(4'b1000, 0, e + 12);
    wait_to(e + 20);
    chk_st("dual_rel3", 4'b0001);
    drv_at(4'b0001, 0, e + 30);
    wait_to(e + 38);
    chk_st("dual_rel0", 4'b0000);
    // reset mid-LONG on channel 2, key still held at reset exit
    e = cyc + 2;
    plan(2, e, e + 20, 0);
    drv_at(4'b0100, 1, e);
    wait_to(e + 22);
    chk_st("long2", 4'b0100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_a", 32'({st_a, pr_a, rl_a, lg_a, rp_a}), 0);
    chk("async_rst_b", 32'({st_b, pr_b, rl_b, lg_b, rp_b}), 0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    r = cyc;
    plan(2, r, r + 25, 1);
    wait_to(r + 6);
    chk_st("re_pre", 4'b0000);
    wait_to(r + 7);
    chk_st("re_press", 4'b0100);
    drv_at(4'b0100, 0, r + 25);
    wait_to(r + 40);
    chk_st("re_rel", 4'b0000);
    chk("sb_empty", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
